change_dispenser: RTL and testbench

- Pays out change for the vending machine, one coin at a time, to a coin hopper.
- The vending FSM presents a change amount with a valid/ready handshake.
- The block breaks the amount into NT$50/10/5/1 coins, largest first, skipping any denomination the hopper reports empty.
- It drives an eject request/acknowledge handshake per coin and reports done or fault back to the FSM.

---
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change amount one coin at a time, largest stocked
// denomination first, through an eject request/acknowledge handshake.
module change_dispenser #(
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  input  logic [3:0]       hopper_empty,
  output logic             eject_valid,
  output logic [3:0]       eject_sel,
  input  logic             eject_ack,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coins_paid,
  output logic             change_done,
  output logic             change_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [3:0]       pick_s;
  logic [AMT_W-1:0] coin_val_s;

  // Largest stocked denomination that does not exceed the amount still owed
  always_comb begin
    pick_s = 4'b0000;
    if (!hopper_empty[3] && (remaining >= AMT_W'(50))) begin
      pick_s = 4'b1000;
    end else if (!hopper_empty[2] && (remaining >= AMT_W'(10))) begin
      pick_s = 4'b0100;
    end else if (!hopper_empty[1] && (remaining >= AMT_W'(5))) begin
      pick_s = 4'b0010;
    end else if (!hopper_empty[0] && (remaining >= AMT_W'(1))) begin
      pick_s = 4'b0001;
    end else begin
      pick_s = 4'b0000;
    end
  end

  // Face value of the coin currently being ejected
  always_comb begin
    coin_val_s = {AMT_W{1'b0}};
    case (eject_sel)
      4'b1000: coin_val_s = AMT_W'(50);
      4'b0100: coin_val_s = AMT_W'(10);
      4'b0010: coin_val_s = AMT_W'(5);
      4'b0001: coin_val_s = AMT_W'(1);
      default: coin_val_s = {AMT_W{1'b0}};
    endcase
  end

  // Next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (change_valid) next_s = SELECT;
        else              next_s = IDLE;
      end
      SELECT: begin
        if (remaining == {AMT_W{1'b0}}) next_s = DONE;
        else if (pick_s != 4'b0000)     next_s = EJECT;
        else                            next_s = IDLE;
      end
      EJECT: begin
        if (eject_ack) next_s = SELECT;
        else           next_s = EJECT;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Registered outputs follow the next state so they line up with it cycle for cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_ready <= 1'b1;
      eject_valid  <= 1'b0;
      eject_sel    <= 4'b0000;
      remaining    <= {AMT_W{1'b0}};
      coins_paid   <= {AMT_W{1'b0}};
      change_done  <= 1'b0;
      change_fault <= 1'b0;
    end else begin
      change_ready <= (next_s == IDLE);
      eject_valid  <= (next_s == EJECT);
      change_done  <= (next_s == DONE);
      change_fault <= (state_r == SELECT) && (next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (change_valid) begin
            remaining  <= change_amount;
            coins_paid <= {AMT_W{1'b0}};
          end
        end
        SELECT: begin
          if (next_s == EJECT) eject_sel <= pick_s;
        end
        EJECT: begin
          // d <= remaining was guaranteed when the coin was picked, so no underflow
          if (eject_ack) begin
            remaining  <= remaining - coin_val_s;
            coins_paid <= coins_paid + AMT_W'(1);
            eject_sel  <= 4'b0000;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: hand-checked vector table, randomized transactions
// against a greedy payout model, and an asynchronous reset during a payout.
module tb_change_dispenser;

  localparam int AMT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic [3:0]       hopper_empty;
  logic             eject_valid;
  logic [3:0]       eject_sel;
  logic             eject_ack;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] coins_paid;
  logic             change_done;
  logic             change_fault;

  change_dispenser #(.AMT_W(AMT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .change_ready (change_ready),
    .hopper_empty (hopper_empty),
    .eject_valid  (eject_valid),
    .eject_sel    (eject_sel),
    .eject_ack    (eject_ack),
    .remaining    (remaining),
    .coins_paid   (coins_paid),
    .change_done  (change_done),
    .change_fault (change_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         amt;
    logic [3:0] empty;
    int         delay;
    bit         toggle;
    int         exp_coins;
    int         exp_rem;
    bit         exp_fault;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int got_q[$];
  int exp_rem;
  bit exp_fault;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input logic [3:0] sel);
    case (sel)
      4'b1000: return 50;
      4'b0100: return 10;
      4'b0010: return 5;
      4'b0001: return 1;
      default: return -1;
    endcase
  endfunction

  // Greedy payout: as many of each stocked denomination as fit, largest first
  task automatic model(input int amt, input logic [3:0] empty);
    int denom[4];
    denom[0] = 50; denom[1] = 10; denom[2] = 5; denom[3] = 1;
    exp_q.delete();
    exp_rem = amt;
    for (int i = 0; i < 4; i++) begin
      if (!empty[3-i]) begin
        while (exp_rem >= denom[i]) begin
          exp_q.push_back(denom[i]);
          exp_rem -= denom[i];
        end
      end
    end
    exp_fault = (exp_rem != 0);
  endtask

  task automatic run_txn(input int amt, input logic [3:0] empty, input int delay,
                         input bit toggle, output int n_coins, output int rem,
                         output bit fault);
    int   w;
    int   last_ack;
    bit   in_coin;
    bit   ended;
    logic [3:0] held;
    model(amt, empty);
    got_q.delete();
    n_coins = -1; rem = -1; fault = 1'b0;
    @(negedge clk);
    check("ready_idle", int'(change_ready), 1);
    hopper_empty  = empty;
    change_amount = AMT_W'(amt);
    change_valid  = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    check("ready_busy", int'(change_ready), 0);
    check("remaining_load", int'(remaining), amt);
    check("coins_clear", int'(coins_paid), 0);
    w = 0; last_ack = -2; in_coin = 1'b0; ended = 1'b0; held = 4'b0000;
    for (int c = 0; c < 2000 && !ended; c++) begin
      @(negedge clk);
      eject_ack = 1'b0;
      if (toggle) begin
        change_valid  = c[0];
        change_amount = AMT_W'($urandom_range(0, 255));
      end else begin
        change_valid = 1'b0;
      end
      if (change_done || change_fault) begin
        ended        = 1'b1;
        change_valid = 1'b0;
        fault        = change_fault;
        rem          = int'(remaining);
        n_coins      = int'(coins_paid);
        check("end_latency", c, last_ack + 2);
        check("done_fault", int'({change_done, change_fault}), exp_fault ? 1 : 2);
        check("remaining_end", int'(remaining), exp_rem);
        check("coins_paid", int'(coins_paid), exp_q.size());
      end else if (eject_valid) begin
        if (!in_coin) begin
          in_coin = 1'b1;
          held    = eject_sel;
          w       = 0;
          check("eject_latency", c, last_ack + 2);
        end
        if (w == delay) begin
          check("sel_stable", int'(eject_sel), int'(held));
          got_q.push_back(coin_value(eject_sel));
          eject_ack = 1'b1;
          in_coin   = 1'b0;
          last_ack  = c;
        end else begin
          w++;
        end
      end else if (toggle) begin
        eject_ack = 1'b1;  // stray ack while no coin is requested
      end
    end
    if (!ended) begin
      check("txn_timeout", 0, 1);
      change_valid = 1'b0;
      eject_ack    = 1'b0;
    end
    check("coin_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("coin_seq", got_q[i], exp_q[i]);
    end
    @(negedge clk);
    check("pulse_end", int'({change_ready, change_done, change_fault}), 4);
  endtask

  vec_t tbl[10];
  int   g_coins;
  int   g_rem;
  bit   g_fault;

  initial begin
    tbl[0] = '{amt: 87,  empty: 4'b0000, delay: 0, toggle: 1'b0, exp_coins: 7,  exp_rem: 0,  exp_fault: 1'b0};
    tbl[1] = '{amt: 0,   empty: 4'b0000, delay: 0, toggle: 1'b0, exp_coins: 0,  exp_rem: 0,  exp_fault: 1'b0};
    tbl[2] = '{amt: 30,  empty: 4'b0100, delay: 0, toggle: 1'b0, exp_coins: 6,  exp_rem: 0,  exp_fault: 1'b0};
    tbl[3] = '{amt: 3,   empty: 4'b0001, delay: 0, toggle: 1'b0, exp_coins: 0,  exp_rem: 3,  exp_fault: 1'b1};
    tbl[4] = '{amt: 7,   empty: 4'b0001, delay: 0, toggle: 1'b0, exp_coins: 1,  exp_rem: 2,  exp_fault: 1'b1};
    tbl[5] = '{amt: 15,  empty: 4'b0000, delay: 5, toggle: 1'b1, exp_coins: 2,  exp_rem: 0,  exp_fault: 1'b0};
    tbl[6] = '{amt: 255, empty: 4'b0000, delay: 1, toggle: 1'b0, exp_coins: 6,  exp_rem: 0,  exp_fault: 1'b0};
    tbl[7] = '{amt: 255, empty: 4'b1000, delay: 0, toggle: 1'b0, exp_coins: 26, exp_rem: 0,  exp_fault: 1'b0};
    tbl[8] = '{amt: 64,  empty: 4'b1111, delay: 0, toggle: 1'b0, exp_coins: 0,  exp_rem: 64, exp_fault: 1'b1};
    tbl[9] = '{amt: 0,   empty: 4'b1111, delay: 0, toggle: 1'b0, exp_coins: 0,  exp_rem: 0,  exp_fault: 1'b0};

    reset         = 1'b0;
    change_valid  = 1'b0;
    change_amount = '0;
    hopper_empty  = 4'b0000;
    eject_ack     = 1'b0;
    @(negedge clk);
    check("reset_flags", int'({change_ready, eject_valid, change_done, change_fault}), 8);
    check("reset_sel", int'(eject_sel), 0);
    check("reset_remaining", int'(remaining), 0);
    check("reset_coins", int'(coins_paid), 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].amt, tbl[i].empty, tbl[i].delay, tbl[i].toggle, g_coins, g_rem, g_fault);
      check("tbl_coins", g_coins, tbl[i].exp_coins);
      check("tbl_rem", g_rem, tbl[i].exp_rem);
      check("tbl_fault", int'(g_fault), int'(tbl[i].exp_fault));
    end

    for (int i = 0; i < 30; i++) begin
      run_txn(int'($urandom_range(0, 255)),
              4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              int'($urandom_range(0, 2)),
              ($urandom_range(0, 4) == 0),
              g_coins, g_rem, g_fault);
    end

    // Reset asserted while the second coin of 60 is waiting for its ack
    @(negedge clk);
    hopper_empty  = 4'b0000;
    change_amount = AMT_W'(60);
    change_valid  = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    check("rst_first_valid", int'(eject_valid), 1);
    check("rst_first_sel", int'(eject_sel), 8);
    eject_ack = 1'b1;
    @(negedge clk);
    eject_ack = 1'b0;
    @(negedge clk);
    check("rst_second_sel", int'({eject_valid, eject_sel}), 20);
    check("rst_mid_remaining", int'(remaining), 10);
    check("rst_mid_coins", int'(coins_paid), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", int'(eject_valid), 0);
    check("rst_async_remaining", int'(remaining), 0);
    check("rst_async_coins", int'(coins_paid), 0);
    check("rst_async_ready", int'(change_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_release", int'({change_ready, change_done, change_fault}), 4);
    run_txn(1, 4'b0000, 0, 1'b0, g_coins, g_rem, g_fault);
    check("rst_after_coins", g_coins, 1);
    check("rst_after_fault", int'(g_fault), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
